joy_scanner: RTL
================

JOY_SCANNER -- requirements
Module: joy_scanner

Interface
REQ-001 Parameter DIV, default 28, clk28 cycles per scan tick (28 -> 1 MHz tick); legal range 2..255.
REQ-002 Parameter GAP, default 1000, idle ticks between scan frames; legal range 1..65535.
REQ-003 Parameter STABLE, default 3, consecutive identical frames required before outputs update; legal range 1..7.
REQ-004 clk28  input  1  system clock; the only clock in the block.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  scanner enable, from the joystick-enable configuration bit.
REQ-007 joy_data  input  1  serial button data from external 74HC165 chain; low = pressed.
REQ-008 joy_load_n  output  1  parallel-load strobe to shift register, active-low.
REQ-009 joy_clk  output  1  shift clock to shift register.
REQ-010 kempston_data  output  8  debounced buttons, active-high: [0]right [1]left [2]down [3]up [4]fire [5]fire2 [6]fire3 [7]always 0.
REQ-011 scan_done  output  1  one-clk28 pulse when a frame completes, whether or not outputs changed.

Function
REQ-012 Prescaler counts 0..DIV-1 while en=1; tick is asserted in the clk28 cycle where count = DIV-1, then the count wraps to 0.
REQ-013 The state machine advances only on tick; states are IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE, GAP.
REQ-014 IDLE -> LOAD on first tick with en=1.
REQ-015 LOAD: joy_load_n=0 and joy_clk=0 for exactly one tick period; then -> SHIFT_LO with bit index 0.
REQ-016 SHIFT_LO: joy_clk=0; on the closing tick, joy_data is sampled into raw[index]; then -> SHIFT_HI.
REQ-017 SHIFT_HI: joy_clk=1 for one tick period; on the closing tick, if index=7 -> DONE, else index+1 -> SHIFT_LO.
REQ-018 The first sampled bit is raw[0]; 8 bits are sampled per frame; raw[7] is captured but discarded from the output.
REQ-019 DONE lasts one tick:
  - scan_done pulses in the first clk28 cycle of DONE;
  - debounce evaluation occurs in that same cycle.
REQ-020 Debounce:
  - if raw = prev_raw, stable_cnt increments, saturating at STABLE;
  - otherwise stable_cnt = 1;
  - prev_raw <= raw.
REQ-021 When the post-update stable_cnt = STABLE, kempston_data <= {1'b0, ~raw[6:0]}, registered; it is visible the clk28 cycle after DONE is entered.
REQ-022 GAP: joy_load_n=1 and joy_clk=0 for GAP ticks; then -> LOAD. A frame is 1+16+1+GAP ticks long.
REQ-023 Outside LOAD, joy_load_n=1; outside SHIFT_HI, joy_clk=0. Both outputs are registered, with no glitches.
REQ-024 When en falls in any state:
  - in the next clk28 cycle the state becomes IDLE, the prescaler is cleared, joy_clk=0, joy_load_n=1, kempston_data=0, stable_cnt=0;
  - a partial frame is discarded, with no scan_done.
REQ-025 When en rises, the first frame begins with a LOAD at the next tick (DIV clk28 cycles later).
REQ-026 With STABLE=1, every frame updates kempston_data.
REQ-027 Simultaneous presses of opposite directions are passed through unmodified.

Reset
REQ-028 While rst_n=0, regardless of clk28:
  - state=IDLE, prescaler=0, index=0;
  - raw=prev_raw=8'hFF, stable_cnt=0;
  - kempston_data=8'h00, joy_load_n=1, joy_clk=0, scan_done=0.
REQ-029 Reset asserted mid-frame takes effect immediately, with no completion of the frame; after release, behaviour matches REQ-025 if en=1.

Verification
REQ-030 DIV=4, GAP=2, STABLE=1, en=1, joy_data serialising 8'b1110_1110 (raw[0] first) -> 8 joy_clk pulses each 4 clk high, joy_load_n low 4 clk beforehand; kempston_data=8'h11 one cycle after scan_done.
REQ-031 STABLE=3, raw=8'hFE held for 3 frames -> kempston_data stays 00 after frames 1 and 2; becomes 8'h01 after frame 3; scan_done pulses 3 times.
REQ-032 STABLE=3, raw alternates 8'hFE/8'hFF every frame -> kempston_data remains 8'h00 indefinitely.
REQ-033 Stable 8'hAF output (kempston_data=8'h50), then en=0 during SHIFT_HI of bit 4 -> next cycle joy_clk=0, kempston_data=0, no scan_done; re-enable -> LOAD after DIV cycles.
REQ-034 rst_n pulsed low mid-SHIFT_LO -> all outputs at reset values asynchronously; frame restarts from LOAD after release.
REQ-035 raw=8'h00 (all pressed) -> kempston_data=8'h7F, bit 7 never set.

Source files
------------

// File: rtl/joy_scanner.sv
// Serial joystick scanner: clocks a 74HC165 chain, samples 8 buttons per frame
// and publishes a debounced Kempston-style button byte.
module joy_scanner #(
    parameter int unsigned DIV    = 28,
    parameter int unsigned GAP    = 1000,
    parameter int unsigned STABLE = 3
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       en,
    input  logic       joy_data,
    output logic       joy_load_n,
    output logic       joy_clk,
    output logic [7:0] kempston_data,
    output logic       scan_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE,
        S_GAP
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  presc;
    logic        tick;
    logic [2:0]  idx, idx_nx;
    logic [15:0] gap_cnt, gap_nx;
    logic [7:0]  raw, prev_raw;
    logic [2:0]  stable_cnt, cnt_nx;
    logic        done_entry;
    logic        eval;

    assign tick = en && (presc == 8'(DIV - 1));

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            gap_cnt <= gap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        gap_nx   = gap_cnt;
        if (!en) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
            gap_nx   = '0;
        end else if (tick) begin
            case (state)
                S_IDLE:     state_nx = S_LOAD;
                S_LOAD: begin
                    state_nx = S_SHIFT_LO;
                    idx_nx   = '0;
                end
                S_SHIFT_LO: state_nx = S_SHIFT_HI;
                S_SHIFT_HI: begin
                    if (idx == 3'd7) begin
                        state_nx = S_DONE;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        state_nx = S_SHIFT_LO;
                    end
                end
                S_DONE: begin
                    state_nx = S_GAP;
                    gap_nx   = '0;
                end
                S_GAP: begin
                    if (gap_cnt == 16'(GAP - 1)) state_nx = S_LOAD;
                    else                         gap_nx   = gap_cnt + 16'd1;
                end
                default:    state_nx = S_IDLE;
            endcase
        end
    end

    // scan_done is high only in the first DONE cycle, so it doubles as the
    // single-shot debounce strobe.
    assign done_entry = (state_nx == S_DONE) && (state != S_DONE);
    assign eval       = (state == S_DONE) && scan_done;

    always_comb begin
        cnt_nx = 3'd1;
        if (raw == prev_raw) begin
            if (stable_cnt >= 3'(STABLE)) cnt_nx = 3'(STABLE);
            else                          cnt_nx = stable_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            presc         <= '0;
            raw           <= '1;
            prev_raw      <= '1;
            stable_cnt    <= '0;
            kempston_data <= '0;
            joy_load_n    <= 1'b1;
            joy_clk       <= 1'b0;
            scan_done     <= 1'b0;
        end else if (!en) begin
            presc         <= '0;
            stable_cnt    <= '0;
            kempston_data <= '0;
            joy_load_n    <= 1'b1;
            joy_clk       <= 1'b0;
            scan_done     <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 8'd1;
            joy_load_n <= (state_nx != S_LOAD);
            joy_clk    <= (state_nx == S_SHIFT_HI);
            scan_done  <= done_entry;
            if (tick && state == S_SHIFT_LO) raw[idx] <= joy_data;
            if (eval) begin
                stable_cnt <= cnt_nx;
                prev_raw   <= raw;
                if (cnt_nx == 3'(STABLE)) kempston_data <= {1'b0, ~raw[6:0]};
            end
        end
    end

endmodule
